// File: rtl/alarm_clk_rtl.sv
// 24-hour alarm clock core: timebase, HH:MM counter, alarm register, keypad entry FSM, ASCII display.
// Define ALARM_PULSE_EN to chop sound_alarm into a 1 Hz square wave during the matching minute.
module alarm_clk_rtl #(
   parameter int CLK_PER_SEC = 256,
   parameter int SEC_PER_MIN = 60,
   parameter int TIMEOUT_SEC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       alarm_button,
   input  logic       time_button,
   input  logic [3:0] key,
   input  logic       fast_watch,
   output logic [7:0] display_ms_hr,
   output logic [7:0] display_ls_hr,
   output logic [7:0] display_ms_min,
   output logic [7:0] display_ls_min,
   output logic       sound_alarm
);

   localparam int CYC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_SEC + 1);

   // Digit [3] is hours tens, [0] is minutes units; every digit is BCD.
   typedef logic [3:0][3:0] hhmm_t;

   typedef enum logic [2:0] {
      SHOW_TIME,
      KEY_STORED,
      KEY_WAITED,
      KEY_ENTRY,
      SET_ALARM_TIME,
      SET_CURRENT_TIME,
      SHOW_ALARM
   } state_t;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [TO_W-1:0]  tout_q, tout_d;
   hhmm_t            time_q, time_d;
   hhmm_t            alarm_q, alarm_d;
   hhmm_t            key_buf_q, key_buf_d;
   logic             armed_q, armed_d;
   logic [3:0][7:0]  disp_q, disp_d;
   logic             sound_q, sound_d;

   logic  one_second, one_minute, key_digit, buf_valid, timed_out;
   hhmm_t shown;

   function automatic hhmm_t bcd_inc(input hhmm_t t);
      hhmm_t r;
      r = t;
      if (t[0] != 4'd9) begin
         r[0] = t[0] + 4'd1;
      end else begin
         r[0] = 4'd0;
         if (t[1] != 4'd5) begin
            r[1] = t[1] + 4'd1;
         end else begin
            r[1] = 4'd0;
            if (t[3] == 4'd2 && t[2] == 4'd3) begin
               r[3] = 4'd0;
               r[2] = 4'd0;
            end else if (t[2] == 4'd9) begin
               r[2] = 4'd0;
               r[3] = t[3] + 4'd1;
            end else begin
               r[2] = t[2] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic hhmm_valid(input hhmm_t t);
      return (t[3] <= 4'd2) && (t[2] <= 4'd9) && (t[1] <= 4'd5) && (t[0] <= 4'd9)
             && !(t[3] == 4'd2 && t[2] > 4'd3);
   endfunction

   always_comb begin
      one_second = (cyc_q == CYC_W'(CLK_PER_SEC - 1));
      one_minute = one_second && (fast_watch || (sec_q == SEC_W'(SEC_PER_MIN - 1)));
      key_digit  = (key <= 4'd9);
      buf_valid  = hhmm_valid(key_buf_q);
      timed_out  = (tout_q >= TO_W'(TIMEOUT_SEC));

      state_d   = state_q;
      cyc_d     = one_second ? '0 : cyc_q + 1'b1;
      sec_d     = sec_q;
      if (one_second) begin
         sec_d = (sec_q == SEC_W'(SEC_PER_MIN - 1)) ? '0 : sec_q + 1'b1;
      end
      tout_d    = tout_q;
      if (one_second && (state_q == KEY_WAITED || state_q == KEY_ENTRY)) begin
         tout_d = tout_q + 1'b1;
      end
      time_d    = one_minute ? bcd_inc(time_q) : time_q;
      alarm_d   = alarm_q;
      armed_d   = armed_q;
      key_buf_d = key_buf_q;

      case (state_q)
         SHOW_TIME: begin
            if (alarm_button) begin
               state_d = SHOW_ALARM;
            end else if (key_digit) begin
               key_buf_d = {12'h000, key};
               state_d   = KEY_STORED;
            end
         end
         KEY_STORED: begin
            tout_d  = '0;
            state_d = KEY_WAITED;
         end
         KEY_WAITED: begin
            if (!key_digit) begin
               state_d = KEY_ENTRY;
            end else if (timed_out) begin
               state_d = SHOW_TIME;
            end
         end
         KEY_ENTRY: begin
            if (alarm_button) begin
               state_d = SET_ALARM_TIME;
            end else if (time_button) begin
               state_d = SET_CURRENT_TIME;
            end else if (key_digit) begin
               key_buf_d = {key_buf_q[2:0], key};
               state_d   = KEY_STORED;
            end else if (timed_out) begin
               state_d = SHOW_TIME;
            end
         end
         SET_ALARM_TIME: begin
            if (buf_valid) begin
               alarm_d = key_buf_q;
               armed_d = 1'b1;
            end
            state_d = SHOW_TIME;
         end
         SET_CURRENT_TIME: begin
            // A load overrides a same-cycle minute tick and restarts the timebase.
            if (buf_valid) begin
               time_d = key_buf_q;
               cyc_d  = '0;
               sec_d  = '0;
            end
            state_d = SHOW_TIME;
         end
         SHOW_ALARM: begin
            if (!alarm_button) begin
               state_d = SHOW_TIME;
            end
         end
         default: state_d = SHOW_TIME;
      endcase

      case (state_q)
         KEY_STORED, KEY_WAITED, KEY_ENTRY: shown = key_buf_q;
         SHOW_ALARM:                        shown = alarm_q;
         default:                           shown = time_q;
      endcase
      for (int i = 0; i < 4; i++) begin
         disp_d[i] = 8'h30 + {4'h0, shown[i]};
      end

`ifdef ALARM_PULSE_EN
      sound_d = armed_q && (time_q == alarm_q) && (cyc_q < CYC_W'(CLK_PER_SEC / 2));
`else
      sound_d = armed_q && (time_q == alarm_q);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SHOW_TIME;
         cyc_q     <= '0;
         sec_q     <= '0;
         tout_q    <= '0;
         time_q    <= '0;
         alarm_q   <= '0;
         key_buf_q <= '0;
         armed_q   <= 1'b0;
         disp_q    <= {4{8'h30}};
         sound_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         sec_q     <= sec_d;
         tout_q    <= tout_d;
         time_q    <= time_d;
         alarm_q   <= alarm_d;
         key_buf_q <= key_buf_d;
         armed_q   <= armed_d;
         disp_q    <= disp_d;
         sound_q   <= sound_d;
      end
   end

   assign display_ms_hr  = disp_q[3];
   assign display_ls_hr  = disp_q[2];
   assign display_ms_min = disp_q[1];
   assign display_ls_min = disp_q[0];
   assign sound_alarm    = sound_q;

endmodule

// File: tb/tb_alarm_clk_rtl.sv
// Scoreboard bench for alarm_clk_rtl: a minute-count reference model queues the expected
// outputs every clock, a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_alarm_clk_rtl;

   localparam int CPS   = 256;
   localparam int SPM   = 60;
   localparam int TOS   = 10;
   localparam logic [3:0] NOKEY = 4'hA;

   logic       clk;
   logic       reset;
   logic       alarm_button;
   logic       time_button;
   logic [3:0] key;
   logic       fast_watch;
   logic [7:0] display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;
   logic       sound_alarm;

   int n_checks = 0;
   int n_fails  = 0;
   bit fast     = 1'b0;

   alarm_clk_rtl #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM), .TIMEOUT_SEC(TOS)) dut (
      .clk           (clk),
      .reset         (reset),
      .alarm_button  (alarm_button),
      .time_button   (time_button),
      .key           (key),
      .fast_watch    (fast_watch),
      .display_ms_hr (display_ms_hr),
      .display_ls_hr (display_ls_hr),
      .display_ms_min(display_ms_min),
      .display_ls_min(display_ls_min),
      .sound_alarm   (sound_alarm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] disp;
      logic        snd;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: time and alarm kept as minutes of the day, the key buffer as a
   // queue of digits, and the timebase as a count of cycles since the last reset/load.
   typedef enum {M_TIME, M_ALARM, M_STORE, M_WAIT, M_ENTRY, M_SETA, M_SETT} mode_e;

   mode_e mode, nxt;
   int    now_min, alarm_min, elapsed, idle_s;
   bit    armed, load, sec_tick, min_tick, isdig, buf_ok;
   int    kbuf[$];
   exp_t  e_new;

   function automatic logic [31:0] asc_min(input int mm);
      int h;
      int m;
      h = mm / 60;
      m = mm % 60;
      return {8'(48 + h / 10), 8'(48 + h % 10), 8'(48 + m / 10), 8'(48 + m % 10)};
   endfunction

   function automatic int buf_minutes();
      return (kbuf[0] * 10 + kbuf[1]) * 60 + kbuf[2] * 10 + kbuf[3];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         mode      = M_TIME;
         now_min   = 0;
         alarm_min = 0;
         armed     = 1'b0;
         elapsed   = 0;
         idle_s    = 0;
         kbuf      = '{0, 0, 0, 0};
         e_new.disp = asc_min(0);
         e_new.snd  = 1'b0;
      end else begin
         if (mode == M_STORE || mode == M_WAIT || mode == M_ENTRY)
            e_new.disp = {8'(48 + kbuf[0]), 8'(48 + kbuf[1]), 8'(48 + kbuf[2]), 8'(48 + kbuf[3])};
         else if (mode == M_ALARM)
            e_new.disp = asc_min(alarm_min);
         else
            e_new.disp = asc_min(now_min);
         e_new.snd = armed && (now_min == alarm_min);
`ifdef ALARM_PULSE_EN
         e_new.snd = e_new.snd && ((elapsed % CPS) < CPS / 2);
`endif
         sec_tick = ((elapsed % CPS) == CPS - 1);
         min_tick = sec_tick && (fast_watch || (((elapsed / CPS) % SPM) == SPM - 1));
         isdig    = (key < 10);
         buf_ok   = (kbuf[0] * 10 + kbuf[1] < 24) && (kbuf[2] * 10 + kbuf[3] < 60);
         load     = 1'b0;
         nxt      = mode;
         case (mode)
            M_TIME:  if (alarm_button) nxt = M_ALARM;
                     else if (isdig) begin kbuf = '{0, 0, 0, int'(key)}; nxt = M_STORE; end
            M_STORE: nxt = M_WAIT;
            M_WAIT:  if (!isdig) nxt = M_ENTRY;
                     else if (idle_s >= TOS) nxt = M_TIME;
            M_ENTRY: if (alarm_button) nxt = M_SETA;
                     else if (time_button) nxt = M_SETT;
                     else if (isdig) begin
                        void'(kbuf.pop_front());
                        kbuf.push_back(int'(key));
                        nxt = M_STORE;
                     end
                     else if (idle_s >= TOS) nxt = M_TIME;
            M_SETA:  begin
                        if (buf_ok) begin alarm_min = buf_minutes(); armed = 1'b1; end
                        nxt = M_TIME;
                     end
            M_SETT:  begin
                        if (buf_ok) begin now_min = buf_minutes(); load = 1'b1; end
                        nxt = M_TIME;
                     end
            M_ALARM: if (!alarm_button) nxt = M_TIME;
            default: nxt = M_TIME;
         endcase
         if (mode == M_STORE) idle_s = 0;
         else if ((mode == M_WAIT || mode == M_ENTRY) && sec_tick) idle_s++;
         if (!load && min_tick) now_min = (now_min + 1) % 1440;
         elapsed = load ? 0 : elapsed + 1;
         mode    = nxt;
      end
      exp_q.push_back(e_new);
   end

   // Monitor: every falling edge, the oldest expectation is compared against the DUT.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] act;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};
         n_checks++;
         if (act !== e.disp) begin
            n_fails++;
            $display("[TB] FAIL display @%0t: got %h expected %h", $time, act, e.disp);
         end
         n_checks++;
         if (sound_alarm !== e.snd) begin
            n_fails++;
            $display("[TB] FAIL sound_alarm @%0t: got %b expected %b", $time, sound_alarm, e.snd);
         end
      end
   end

   task automatic applyStimulus(input logic ab, input logic tb, input logic [3:0] k,
                                input logic fw, input int n);
      alarm_button = ab;
      time_button  = tb;
      key          = k;
      fast_watch   = fw;
      repeat (n) @(negedge clk);
   endtask

   task automatic pressKey(input logic [3:0] d);
      applyStimulus(1'b0, 1'b0, d, fast, 2);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 2);
   endtask

   task automatic enterDigits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
      pressKey(a);
      pressKey(b);
      pressKey(c);
      pressKey(d);
   endtask

   task automatic commitTime();
      applyStimulus(1'b0, 1'b1, NOKEY, fast, 1);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 4);
   endtask

   task automatic commitAlarm();
      applyStimulus(1'b1, 1'b0, NOKEY, fast, 1);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 4);
   endtask

   // Direct checks against hand-derived display strings at settled points.
   task automatic checkOutput(input string name, input string exp_s, input logic exp_snd);
      logic [31:0] want;
      logic [31:0] act;
      want = {exp_s[0], exp_s[1], exp_s[2], exp_s[3]};
      act  = {display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};
      n_checks++;
      if (act !== want || sound_alarm !== exp_snd) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h/%b expected %h/%b", name, act, sound_alarm, want, exp_snd);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      alarm_button = 1'b0;
      time_button  = 1'b0;
      key          = NOKEY;
      fast_watch   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", "0000", 1'b0);
      reset = 1'b0;

      fast = 1'b1;
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 260);
      checkOutput("first_fast_minute", "0001", 1'b0);

      enterDigits(4'd1, 4'd2, 4'd3, 4'd0);
      commitTime();
      checkOutput("load_1230", "1230", 1'b0);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 30 * CPS + 10);
      checkOutput("thirty_min_1300", "1300", 1'b0);

      enterDigits(4'd2, 4'd3, 4'd5, 4'd9);
      commitTime();
      checkOutput("load_2359", "2359", 1'b0);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 260);
      checkOutput("hour_wrap", "0000", 1'b0);

      enterDigits(4'd0, 4'd0, 4'd0, 4'd0);
      commitTime();
      enterDigits(4'd0, 4'd0, 4'd0, 4'd1);
      commitAlarm();
      checkOutput("alarm_armed_quiet", "0000", 1'b0);
      applyStimulus(1'b1, 1'b0, NOKEY, fast, 5);
      checkOutput("show_alarm", "0001", 1'b0);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 3);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 240);
      checkOutput("alarm_sounding", "0001", 1'b1);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 256);
      checkOutput("alarm_ended", "0002", 1'b0);

      fast = 1'b0;
      enterDigits(4'd9, 4'd9, 4'd9, 4'd9);
      commitTime();
      checkOutput("invalid_ignored", "0002", 1'b0);

      pressKey(4'd5);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 5 * CPS);
      checkOutput("entry_pending", "0005", 1'b0);
      applyStimulus(1'b0, 1'b0, NOKEY, fast, 6 * CPS);
      checkOutput("entry_timeout", "0002", 1'b0);

      // Random phase: scoreboard-only checking of mixed keys, buttons and speed changes.
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [3:0] k;
         r = $urandom_range(0, 99);
         k = (r < 50) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
         if ($urandom_range(0, 19) == 0) fast = ~fast;
         if (r < 3)
            applyStimulus(1'b0, 1'b0, NOKEY, fast, 2700);
         else
            applyStimulus($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, k, fast,
                          $urandom_range(1, 12));
      end

      applyStimulus(1'b0, 1'b0, NOKEY, fast, 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
